// File: rtl/cnt_job_dispatcher.sv
// Job queue feeding a downstream counter FSM: accepted jobs are issued one at a time as an o_run pulse 2 edges after push.
// Backpressure: rejected pushes (full or zero count) raise o_push_err; issue waits for i_idle, completion waits for i_done.
module cnt_job_dispatcher #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [CNT_W-1:0] i_push_num,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_push_err,
  output logic             o_run,
  output logic [CNT_W-1:0] o_num_cnt,
  input  logic             i_idle,
  input  logic             i_done,
  output logic             o_busy,
  output logic [7:0]       o_job_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      occ_q, occ_d;
  logic             full_q, empty_q, push_err_q, run_q;
  logic [CNT_W-1:0] num_q;
  logic [7:0]       job_cnt_q;
  logic             push_ok, pop, done_evt, busy;

  // Full blocks pushes even when a pop lands on the same edge: no bypass path.
  assign push_ok  = i_push && !full_q && (i_push_num != '0);
  assign pop      = (state_q == S_IDLE) && (occ_q != '0) && i_idle;
  assign done_evt = (state_q == S_WAIT) && i_done;

  always_comb begin
    occ_d = occ_q;
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= i_push_num;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      push_err_q <= 1'b0;
      run_q      <= 1'b0;
      num_q      <= '0;
      job_cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
        num_q    <= mem[rd_ptr_q];
      end
      occ_q      <= occ_d;
      full_q     <= (occ_d == OCC_FULL);
      empty_q    <= (occ_d == '0);
      push_err_q <= i_push && !push_ok;
      run_q      <= pop;
      if (done_evt) job_cnt_q <= job_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = pop ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = i_done ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    case (state_q)
      S_ISSUE, S_WAIT: busy = 1'b1;
      default:         busy = 1'b0;
    endcase
  end

  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_push_err = push_err_q;
  assign o_run      = run_q;
  assign o_num_cnt  = num_q;
  assign o_busy     = busy;
  assign o_job_cnt  = job_cnt_q;

endmodule

// File: tb/tb_cnt_job_dispatcher.sv
// Scoreboard bench for cnt_job_dispatcher with a simple downstream counter model.
module tb_cnt_job_dispatcher;

  localparam int DEPTH = 4;
  localparam int CNT_W = 7;

  logic             clk;
  logic             reset_n;
  logic             i_push;
  logic [CNT_W-1:0] i_push_num;
  logic             o_full, o_empty, o_push_err, o_run, o_busy;
  logic [CNT_W-1:0] o_num_cnt;
  logic             i_idle, i_done;
  logic [7:0]       o_job_cnt;

  logic ds_en, ds_idle, ds_done, man_idle, man_done;
  int   ds_st, ds_wait, ds_dones;
  logic prev_run;
  logic [CNT_W-1:0] exp_v;
  logic [CNT_W-1:0] sb [$];
  int   n_vec, n_err;

  assign i_idle = ds_en ? ds_idle : man_idle;
  assign i_done = ds_en ? ds_done : man_done;

  cnt_job_dispatcher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (i_push),
    .i_push_num (i_push_num),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_push_err (o_push_err),
    .o_run      (o_run),
    .o_num_cnt  (o_num_cnt),
    .i_idle     (i_idle),
    .i_done     (i_done),
    .o_busy     (o_busy),
    .o_job_cnt  (o_job_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Downstream counter: leaves IDLE on o_run, reports DONE a few cycles later, then returns to IDLE.
  initial begin
    ds_st = 0; ds_wait = 0; ds_dones = 0; ds_idle = 1'b1; ds_done = 1'b0;
  end
  always @(negedge clk) begin
    if (!ds_en) begin
      ds_st = 0; ds_idle = 1'b1; ds_done = 1'b0;
    end else begin
      case (ds_st)
        0: if (o_run) begin ds_idle = 1'b0; ds_wait = 2; ds_st = 1; end
        1: if (ds_wait == 0) begin ds_done = 1'b1; ds_st = 2; end
           else ds_wait--;
        2: begin ds_done = 1'b0; ds_dones++; ds_st = 3; end
        default: begin ds_idle = 1'b1; ds_st = 0; end
      endcase
    end
  end

  initial prev_run = 1'b0;
  always @(negedge clk) begin
    if (o_run) begin
      if (prev_run) chk("run_width", 32'(prev_run & o_run), 0);
      if (sb.size() == 0) chk("run_no_job", 32'(o_run), 0);
      else begin
        exp_v = sb.pop_front();
        chk("num_cnt", 32'(o_num_cnt), 32'(exp_v));
      end
      chk("busy_on_run", 32'(o_busy), 1);
    end
    prev_run = o_run;
  end

  task automatic push_job(input logic [CNT_W-1:0] v, input bit ok);
    i_push = 1'b1;
    i_push_num = v;
    @(negedge clk);
    i_push = 1'b0;
    i_push_num = '0;
    chk("push_err", 32'(o_push_err), 32'(!ok));
    if (ok) sb.push_back(v);
  endtask

  task automatic wait_jobs(input logic [7:0] tgt, input string tag);
    int t = 0;
    while (o_job_cnt != tgt && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 32'(o_job_cnt), 32'(tgt));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(o_empty), 1);
    chk({tag, "_full"}, 32'(o_full), 0);
    chk({tag, "_run"}, 32'(o_run), 0);
    chk({tag, "_num"}, 32'(o_num_cnt), 0);
    chk({tag, "_err"}, 32'(o_push_err), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_jobs"}, 32'(o_job_cnt), 0);
  endtask

  initial begin
    int start, t;
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; i_push = 1'b0; i_push_num = '0;
    man_idle = 1'b1; man_done = 1'b0; ds_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;

    // Single job through the downstream model
    ds_en = 1'b1;
    push_job(7'd100, 1'b1);
    wait_jobs(8'd1, "jobs_single");
    chk("busy_after_done", 32'(o_busy), 0);
    chk("num_held", 32'(o_num_cnt), 100);

    // Zero-count push is rejected
    push_job(7'd0, 1'b0);
    chk("zero_empty", 32'(o_empty), 1);
    repeat (4) @(negedge clk);
    chk("zero_still_empty", 32'(o_empty), 1);

    // Fill the queue while downstream is busy, overflow, then drain in order
    ds_en = 1'b0; man_idle = 1'b0;
    push_job(7'd10, 1'b1);
    push_job(7'd20, 1'b1);
    push_job(7'd30, 1'b1);
    push_job(7'd40, 1'b1);
    chk("full_after_4", 32'(o_full), 1);
    push_job(7'd50, 1'b0);
    chk("full_after_ovf", 32'(o_full), 1);
    @(negedge clk);
    chk("err_one_cycle", 32'(o_push_err), 0);
    ds_en = 1'b1;
    wait_jobs(8'd5, "jobs_drain4");
    chk("drain_empty", 32'(o_empty), 1);
    chk("drain_sb", 32'(sb.size()), 0);

    // Push against a full queue on the same edge as a pop
    ds_en = 1'b0; man_idle = 1'b0;
    push_job(7'd1, 1'b1);
    push_job(7'd2, 1'b1);
    push_job(7'd3, 1'b1);
    push_job(7'd4, 1'b1);
    chk("full_before_pop", 32'(o_full), 1);
    man_idle = 1'b1; i_push = 1'b1; i_push_num = 7'd9;
    @(negedge clk);
    man_idle = 1'b0; i_push = 1'b0; i_push_num = '0;
    chk("pop_push_err", 32'(o_push_err), 1);
    chk("pop_push_full", 32'(o_full), 0);
    chk("pop_push_empty", 32'(o_empty), 0);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("done_in_issue", 32'(o_job_cnt), 5);
    chk("busy_in_wait", 32'(o_busy), 1);
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("done_in_wait", 32'(o_job_cnt), 6);
    ds_en = 1'b1;
    wait_jobs(8'd9, "jobs_after_pop_push");
    chk("pp_empty", 32'(o_empty), 1);
    chk("pp_sb", 32'(sb.size()), 0);

    // Reset while waiting with two jobs still queued
    ds_en = 1'b0; man_idle = 1'b0;
    push_job(7'd7, 1'b1);
    push_job(7'd8, 1'b1);
    push_job(7'd9, 1'b1);
    man_idle = 1'b1;
    @(negedge clk);
    man_idle = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(o_busy), 1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("midrst");
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    man_done = 1'b1; man_idle = 1'b1;
    repeat (5) @(negedge clk);
    man_done = 1'b0;
    chk("post_rst_jobs", 32'(o_job_cnt), 0);
    chk("post_rst_empty", 32'(o_empty), 1);

    // 256 single-count jobs: completion counter wraps to zero
    ds_en = 1'b1;
    start = ds_dones;
    for (int i = 0; i < 256; i++) begin
      t = 0;
      while (o_full && t < 1000) begin
        @(negedge clk);
        t++;
      end
      push_job(7'd1, 1'b1);
    end
    t = 0;
    while ((ds_dones - start) < 256 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("wrap_completions", 32'(ds_dones - start), 256);
    repeat (3) @(negedge clk);
    chk("wrap_jobs", 32'(o_job_cnt), 0);
    chk("wrap_empty", 32'(o_empty), 1);
    chk("wrap_sb", 32'(sb.size()), 0);
    chk("wrap_busy", 32'(o_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cnt_job_dispatcher.md
CNT_JOB_DISPATCHER -- requirements
Module: cnt_job_dispatcher

Interface
REQ-001 Parameter DEPTH, default 4, job queue entries (power of 2, 2..16).
REQ-002 Parameter CNT_W, default 7, width of a count job.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_push  input  1  write job i_push_num into queue this cycle.
REQ-006 i_push_num  input  CNT_W  count value of job being pushed.
REQ-007 o_full  output  1  queue holds DEPTH jobs.
REQ-008 o_empty  output  1  queue holds zero jobs.
REQ-009 o_push_err  output  1  one-cycle pulse: push rejected (full or zero count).
REQ-010 o_run  output  1  one-cycle start pulse to downstream counter FSM.
REQ-011 o_num_cnt  output  CNT_W  count value presented with o_run; held until next issue.
REQ-012 i_idle  input  1  downstream counter in IDLE.
REQ-013 i_done  input  1  downstream counter in DONE.
REQ-014 o_busy  output  1  dispatcher in ISSUE or WAIT.
REQ-015 o_job_cnt  output  8  number of completed jobs, wraps 255->0.

Function
REQ-016 Queue SHALL be a circular FIFO of DEPTH x CNT_W with read/write pointers and an occupancy count of log2(DEPTH)+1 bits.
REQ-017 Push accepted when i_push=1, o_full=0, i_push_num!=0; entry written at write pointer, pointer wraps DEPTH-1->0.
REQ-018 Push with o_full=1 or i_push_num=0 SHALL be discarded, queue unchanged, o_push_err=1 next cycle for exactly one cycle.
REQ-019 o_full/o_empty SHALL be registered, derived from post-update occupancy; no push bypass when full, even if a pop occurs same cycle.
REQ-020 Simultaneous accepted push and pop SHALL leave occupancy unchanged.
REQ-021 FSM states: S_IDLE, S_ISSUE, S_WAIT (encoding 2'b00, 2'b01, 2'b10; 2'b11 returns to S_IDLE).
REQ-022 S_IDLE -> S_ISSUE when occupancy!=0 and i_idle=1 (both sampled at current edge); head entry popped on this transition.
REQ-023 On entering S_ISSUE, o_run=1 and o_num_cnt=popped value, both registered; o_run high exactly one cycle.
REQ-024 S_ISSUE -> S_WAIT unconditionally after one cycle.
REQ-025 S_WAIT -> S_IDLE on first cycle i_done=1; o_job_cnt increments by 1 on that transition.
REQ-026 i_done while in S_IDLE or S_ISSUE SHALL be ignored (no count, no transition).
REQ-027 Latency: job pushed at edge N into empty queue, FSM in S_IDLE, i_idle=1 -> o_run=1 during cycle after edge N+1.
REQ-028 After S_WAIT->S_IDLE, next issue SHALL wait for i_idle=1; back-to-back jobs thus separated by downstream DONE->IDLE return.
REQ-029 o_busy = 1 in S_ISSUE and S_WAIT, 0 in S_IDLE.
REQ-030 No deadlock timeout; S_WAIT holds indefinitely without i_done.

Reset
REQ-031 reset_n=0 SHALL immediately clear: FSM=S_IDLE, pointers and occupancy=0, o_empty=1, o_full=0, o_run=0, o_num_cnt=0, o_push_err=0, o_busy=0, o_job_cnt=0.
REQ-032 Reset mid-job SHALL discard all queued jobs; no o_run pulse after release until a new push.
REQ-033 Queue storage contents need no reset; never read while empty.

Verification
REQ-034 Reset, push 100, i_idle=1 -> o_run one cycle, o_num_cnt=100, o_busy=1; i_done pulse -> o_job_cnt=1, o_busy=0.
REQ-035 Push 10,20,30,40 with i_idle=0 -> o_full=1; fifth push 50 -> o_push_err pulse, queue unchanged; release i_idle, model downstream -> issues 10,20,30,40 in order, o_job_cnt=4, o_empty=1.
REQ-036 Push i_push_num=0 -> o_push_err pulse, o_empty stays 1, no o_run.
REQ-037 Queue full, FSM pops while i_push=1 same edge -> push rejected, o_push_err=1, occupancy DEPTH-1.
REQ-038 Assert reset_n=0 in S_WAIT with 2 jobs queued -> all outputs at reset values asynchronously; i_done after release -> o_job_cnt stays 0.
REQ-039 Run 256 jobs of count 1 through downstream model -> o_job_cnt wraps to 0, no lost or duplicated job.
